world_map_arbiter: RTL
======================

Name: world_map_arbiter

Overview:
- Shares the single read port of the synchronous 128x128x2 world-map memory between two requesters.
  - Video scan path: feeds the pixel colorizer and has a hard deadline.
  - Bot sensor path: Rojobot location/sensor lookups, elastic.
- Video has absolute priority with fixed read latency; bot reads fill idle slots under a req/ack handshake.
- Sits between the DTG-driven video address generator, the bot logic and the world-map memory.

Parameters:
- ADDR_W, 14, world-map address width {row[6:0], col[6:0]}
- PIX_W, 2, world-map pixel width
- STARVE_LIMIT, 64, consecutive bot wait cycles before bot_starve asserts

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vid_req  in  1  video read request, sampled every clk
- vid_addr  in  ADDR_W  video read address, valid with vid_req
- vid_valid  out  1  video pixel valid, exactly 3 clk after vid_req
- vid_pixel  out  PIX_W  video pixel data
- bot_req  in  1  bot read request (level)
- bot_addr  in  ADDR_W  bot address, held stable while bot_req high until bot_ack
- bot_ack  out  1  one-cycle pulse, bot_pixel valid
- bot_pixel  out  PIX_W  bot pixel data, held until next bot_ack
- bot_starve  out  1  bot waited >= STARVE_LIMIT consecutive cycles
- mem_addr  out  ADDR_W  registered memory address
- mem_data  in  PIX_W  memory read data, valid 1 clk after mem_addr

Behaviour:
- Reset (async assert, sync release): all outputs 0; in-flight reads discarded; no vid_valid or bot_ack produced for requests issued before reset.
- Issue slot, one per clk:
  - If vid_req is high, issue video: mem_addr <= vid_addr, tag VID.
  - Otherwise, if bot_req is high and state is IDLE, issue bot: mem_addr <= bot_addr, tag BOT.
  - Otherwise, tag NONE and mem_addr holds its value.
- Pipeline and latency:
  - Cycle 0: issue sampled.
  - Cycle 1: mem_addr registered, tag stage 1.
  - Cycle 2: mem_data valid, tag stage 2.
  - Cycle 3: vid_pixel/bot_pixel registered from mem_data; vid_valid or bot_ack asserted per tag.
  - Latency is 3 clk for both paths.
- Video throughput: one request per clk sustained; back-to-back vid_req gives back-to-back vid_valid; vid_pixel holds its last value when vid_valid is low.
- Bot FSM states:
  - IDLE: if bot_req is high and the slot is free (vid_req low), go to WAIT_DATA with a 2-bit countdown at 2.
  - WAIT_DATA: decrement; at 0 go to ACK.
  - ACK: bot_ack=1, bot_pixel updated; go to IDLE.
  - bot_req high during ACK is not a new request; earliest reissue is the cycle after ACK. Max bot throughput is 1 per 4 clk.
- Bot contention: when vid_req and bot_req are high in the same cycle, video wins and the bot stays in IDLE. A bot read already in WAIT_DATA/ACK is never preempted, because it has already used its slot.
- bot_req dropped before the grant: the request is withdrawn and no ack is produced. bot_req dropped after the grant: the ack is still produced.
- Starvation monitor:
  - wait_cnt (7 bits) increments, saturating, each cycle bot_req is high and the FSM is IDLE without a grant; it clears on grant or when bot_req is low.
  - bot_starve = (wait_cnt >= STARVE_LIMIT), registered.
- Reset mid-transaction: the FSM returns to IDLE, tags clear, and bot_ack is not issued; the bot must re-request.

Optional Feature:
- Macro: WORLD_MAP_ARB_STATS_EN.
- Defined:
  - Adds output vid_rd_cnt[15:0], counting video issues.
  - Adds output bot_rd_cnt[15:0], counting bot acks.
  - Adds input stats_clr, a synchronous clear.
  - Both counters saturate at 16'hFFFF, reset to 0, and stats_clr has priority over increment.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package world_map_pkg: ADDR_W, PIX_W, read latency constant RD_LAT=3, tag encoding (NONE=2'b00, VID=2'b01, BOT=2'b10), and world pixel codes (BACKGROUND=2'b00, BLACK_LINE=2'b01, OBSTRUCTION=2'b10, RESERVED=2'b11).
- Sub-module world_map_rd_tag_pipe: 2-stage tag shift register that aligns the tag with mem_data. The arbiter instantiates it once.

Test Plan:
- Reset: hold reset_n=0 with vid_req=1 and bot_req=1 -> all outputs 0; release -> first vid_valid exactly 3 clk after first sampled vid_req.
- Video stream: preload mem[0x0105]=2'b10; vid_req on 4 consecutive cycles, addr 0x0102..0x0105 -> vid_valid high on 4 consecutive cycles starting cycle +3; last vid_pixel=2'b10; mem_addr sequence matches.
- Bot idle-slot read: preload mem[0x1F7F]=2'b01; bot_req=1, addr 0x1F7F, vid_req=0 -> bot_ack at +3, bot_pixel=2'b01; bot_req held -> next ack no earlier than +7.
- Contention: vid_req high every other cycle with bot_req=1 -> bot issued only in vid_req=0 cycles; video latency stays exactly 3; no missed vid_valid.
- Starvation: vid_req=1 continuously for 80 clk with bot_req=1 -> bot_starve rises when wait_cnt reaches 64 (64 clk after bot_req first sampled); drop vid_req -> bot granted next clk, bot_starve clears 1 clk after grant.
- Reset mid-read: assert reset_n=0 one clk after a bot grant -> no bot_ack after release; with WORLD_MAP_ARB_STATS_EN defined, 10 video reads then stats_clr -> vid_rd_cnt=10, then 0.

Source files
------------

// File: rtl/world_map_pkg.sv
// Shared constants for the world-map read arbiter: geometry, read latency,
// read-tag encoding and world pixel codes.
package world_map_pkg;

    localparam int ADDR_W = 14;  // {row[6:0], col[6:0]}
    localparam int PIX_W  = 2;
    localparam int RD_LAT = 3;   // issue to vid_valid / bot_ack, in clk

    // Owner of the read travelling down the pipeline
    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_VID  = 2'b01,
        TAG_BOT  = 2'b10
    } rd_tag_e;

    // World pixel codes stored in the map
    localparam logic [1:0] BACKGROUND  = 2'b00;
    localparam logic [1:0] BLACK_LINE  = 2'b01;
    localparam logic [1:0] OBSTRUCTION = 2'b10;
    localparam logic [1:0] RESERVED    = 2'b11;

endpackage

// File: rtl/world_map_rd_tag_pipe.sv
// Two-stage shift register carrying the read owner tag so that it lines up
// with mem_data (one clk after the registered mem_addr).
module world_map_rd_tag_pipe (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] tag_i,
    output logic [1:0] tag_o
);
    import world_map_pkg::*;

    logic [1:0] tag_s1_q;
    logic [1:0] tag_s2_q;

    // Shift the issue tag through two stages; reset drops any in-flight read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_s1_q <= TAG_NONE;
            tag_s2_q <= TAG_NONE;
        end else begin
            tag_s1_q <= tag_i;
            tag_s2_q <= tag_s1_q;
        end
    end

    assign tag_o = tag_s2_q;

endmodule

// File: rtl/world_map_arbiter.sv
// Shares the world-map read port between the video scan path (absolute
// priority, fixed 3-clk latency) and the bot sensor path (req/ack, idle slots).
// Optional read statistics are built when WORLD_MAP_ARB_STATS_EN is defined.
module world_map_arbiter #(
    parameter int ADDR_W       = world_map_pkg::ADDR_W,
    parameter int PIX_W        = world_map_pkg::PIX_W,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [PIX_W-1:0]  vid_pixel,
    input  logic              bot_req,
    input  logic [ADDR_W-1:0] bot_addr,
    output logic              bot_ack,
    output logic [PIX_W-1:0]  bot_pixel,
    output logic              bot_starve,
`ifdef WORLD_MAP_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       vid_rd_cnt,
    output logic [15:0]       bot_rd_cnt,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_data
);
    import world_map_pkg::*;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_DATA = 2'd1;
    localparam logic [1:0] S_ACK       = 2'd2;

    localparam logic [6:0] STARVE_LIM7 = 7'(STARVE_LIMIT);

    logic [1:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [6:0]        wait_cnt_q, wait_cnt_d;
    logic              starve_q;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    rd_tag_e           tag_issue;
    logic              grant_bot;
    logic [1:0]        tag_s2;
    logic              vid_valid_q, bot_ack_q;
    logic [PIX_W-1:0]  vid_pixel_q, bot_pixel_q;

    // Issue slot: video always wins, bot only when its FSM is idle
    always_comb begin
        grant_bot  = 1'b0;
        tag_issue  = TAG_NONE;
        mem_addr_d = mem_addr_q;
        if (vid_req) begin
            tag_issue  = TAG_VID;
            mem_addr_d = vid_addr;
        end else if (bot_req && (state_q == S_IDLE)) begin
            grant_bot  = 1'b1;
            tag_issue  = TAG_BOT;
            mem_addr_d = bot_addr;
        end
    end

    // Bot FSM: a granted read cannot be preempted; ACK blocks immediate reissue
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_bot) begin
                    state_d = S_WAIT_DATA;
                    cnt_d   = 2'd2;
                end
            end
            S_WAIT_DATA: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = S_ACK;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Consecutive cycles the bot sits idle-but-refused; saturates at 127
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bot_req || grant_bot) begin
            wait_cnt_d = '0;
        end else if ((state_q == S_IDLE) && (wait_cnt_q != 7'h7F)) begin
            wait_cnt_d = wait_cnt_q + 7'd1;
        end
    end

    // Control state: FSM, starvation monitor and registered memory address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wait_cnt_q <= '0;
            starve_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_cnt_q <= wait_cnt_d;
            starve_q   <= (wait_cnt_d >= STARVE_LIM7);
            mem_addr_q <= mem_addr_d;
        end
    end

    world_map_rd_tag_pipe u_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_i   (tag_issue),
        .tag_o   (tag_s2)
    );

    // Return stage: capture mem_data for the owner of the read, hold otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_valid_q <= 1'b0;
            vid_pixel_q <= '0;
            bot_ack_q   <= 1'b0;
            bot_pixel_q <= '0;
        end else begin
            vid_valid_q <= (tag_s2 == TAG_VID);
            bot_ack_q   <= (tag_s2 == TAG_BOT);
            if (tag_s2 == TAG_VID) vid_pixel_q <= mem_data;
            if (tag_s2 == TAG_BOT) bot_pixel_q <= mem_data;
        end
    end

    assign vid_valid  = vid_valid_q;
    assign vid_pixel  = vid_pixel_q;
    assign bot_ack    = bot_ack_q;
    assign bot_pixel  = bot_pixel_q;
    assign bot_starve = starve_q;
    assign mem_addr   = mem_addr_q;

`ifdef WORLD_MAP_ARB_STATS_EN
    logic [15:0] vid_rd_cnt_q, bot_rd_cnt_q;

    // Saturating read counters; clear beats increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_rd_cnt_q <= '0;
            bot_rd_cnt_q <= '0;
        end else if (stats_clr) begin
            vid_rd_cnt_q <= '0;
            bot_rd_cnt_q <= '0;
        end else begin
            if ((tag_issue == TAG_VID) && (vid_rd_cnt_q != 16'hFFFF))
                vid_rd_cnt_q <= vid_rd_cnt_q + 16'd1;
            if ((tag_s2 == TAG_BOT) && (bot_rd_cnt_q != 16'hFFFF))
                bot_rd_cnt_q <= bot_rd_cnt_q + 16'd1;
        end
    end

    assign vid_rd_cnt = vid_rd_cnt_q;
    assign bot_rd_cnt = bot_rd_cnt_q;
`endif

endmodule
